// File: rtl/alu_mul_ctrl_pkg.sv
// Shared constants for the shift-and-add multiply sequencer: datapath width,
// the borrowed ALU opcode and the sequencer state encoding.
package alu_mul_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [3:0] ALU_ADD = 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_ctrl.sv
// Multi-cycle MUL (low XLEN bits) that borrows the shared ALU's ADD, one
// multiplier bit per cycle, with early exit once the remaining multiplier is zero.
import alu_mul_ctrl_pkg::*;

module alu_mul_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_in_0,
  output logic [XLEN-1:0] alu_in_1,
  output logic [3:0]      alu_operation,
  input  logic [XLEN-1:0] alu_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              alu_req_q, alu_req_d;

  // Next-state and datapath update; status flags decode the next state so they come straight from flops.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          if (op_b != '0) begin
            state_d = S_RUN;
          end else begin
            state_d  = S_DONE;
            result_d = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if ((mplier_d == '0) || (cnt_q == CNT_LAST)) begin
          state_d  = S_DONE;
          result_d = alu_out;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    alu_req_d = (state_d == S_RUN);
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      alu_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      alu_req_q <= alu_req_d;
    end
  end

  // ALU operands are forced to zero whenever the ALU belongs to someone else.
  always_comb begin
    if (alu_req_q) begin
      alu_in_0 = acc_q;
      alu_in_1 = mplier_q[0] ? mcand_q : '0;
    end else begin
      alu_in_0 = '0;
      alu_in_1 = '0;
    end
  end

  assign alu_operation = ALU_ADD;
  assign busy          = busy_q;
  assign done          = done_q;
  assign alu_req       = alu_req_q;
  assign result        = result_q;

endmodule
